// File: rtl/ysyx_23060077_ex2wb.sv
// Execute-to-writeback buffer: a 2-entry in-order FIFO of writeback fields.
// Control-transfer targets are computed on acceptance and issued as a one-cycle redirect pulse.
module ysyx_23060077_ex2wb #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     in_pc,
    input  logic [DATA_WIDTH-1:0]     in_result,
    input  logic [DATA_WIDTH-1:0]     in_imm,
    input  logic [DATA_WIDTH-1:0]     in_src1,
    input  logic                      in_branch,
    input  logic                      in_jal,
    input  logic                      in_jalr,
    input  logic [REG_ADDR_WIDTH-1:0] in_rd,
    input  logic                      in_rd_wen,
    input  logic                      flush,
    output logic                      wb_valid,
    input  logic                      wb_ready,
    output logic [REG_ADDR_WIDTH-1:0] wb_rd,
    output logic [DATA_WIDTH-1:0]     wb_data,
    output logic                      wb_wen,
    output logic                      redirect_valid,
    output logic [DATA_WIDTH-1:0]     redirect_pc,
    output logic                      redirect_misalign
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e                    state_q, state_d;
    logic                      rdPtr_q, rdPtr_d;
    logic                      wrPtr_q, wrPtr_d;
    logic [DATA_WIDTH-1:0]     dataMem_q [2];
    logic [REG_ADDR_WIDTH-1:0] rdMem_q   [2];
    logic [1:0]                wenMem_q;
    logic                      redirValid_q;
    logic [DATA_WIDTH-1:0]     redirPc_q;
    logic                      redirMis_q;

    logic                  inXfer;
    logic                  outXfer;
    logic                  entryWen;
    logic                  takeRedir;
    logic                  issueRedir;
    logic [DATA_WIDTH-1:0] target;

    assign in_ready   = (state_q != FULL);
    assign wb_valid   = (state_q != EMPTY);
    assign inXfer     = in_valid && in_ready && !flush;
    assign outXfer    = wb_valid && wb_ready;

    // x0 is hard-wired zero and branches never produce a register result
    assign entryWen   = in_rd_wen && (in_rd != '0) && !in_branch;
    assign takeRedir  = (in_branch && in_result[0]) || in_jal || in_jalr;
    assign issueRedir = inXfer && takeRedir;
    assign target     = in_jalr ? ((in_src1 + in_imm) & {{(DATA_WIDTH-1){1'b1}}, 1'b0})
                                : (in_pc + in_imm);

    assign wb_rd             = rdMem_q[rdPtr_q];
    assign wb_data           = dataMem_q[rdPtr_q];
    assign wb_wen            = wenMem_q[rdPtr_q];
    assign redirect_valid    = redirValid_q;
    assign redirect_pc       = redirPc_q;
    assign redirect_misalign = redirMis_q;

    always_comb begin
        state_d = state_q;
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        if (flush) begin
            state_d = EMPTY;
            rdPtr_d = 1'b0;
            wrPtr_d = 1'b0;
        end else begin
            if (inXfer) wrPtr_d = ~wrPtr_q;
            if (outXfer) rdPtr_d = ~rdPtr_q;
            case (state_q)
                EMPTY:   if (inXfer) state_d = ONE;
                ONE: begin
                    if (inXfer && !outXfer) state_d = FULL;
                    else if (!inXfer && outXfer) state_d = EMPTY;
                end
                FULL:    if (outXfer) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= EMPTY;
            rdPtr_q      <= 1'b0;
            wrPtr_q      <= 1'b0;
            dataMem_q[0] <= '0;
            dataMem_q[1] <= '0;
            rdMem_q[0]   <= '0;
            rdMem_q[1]   <= '0;
            wenMem_q     <= '0;
            redirValid_q <= 1'b0;
            redirPc_q    <= '0;
            redirMis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            if (inXfer) begin
                dataMem_q[wrPtr_q] <= in_result;
                rdMem_q[wrPtr_q]   <= in_rd;
                wenMem_q[wrPtr_q]  <= entryWen;
            end
            // Redirect fields stay zero outside the single pulse cycle
            redirValid_q <= issueRedir;
            redirPc_q    <= issueRedir ? target : '0;
            redirMis_q   <= issueRedir && target[1];
        end
    end

endmodule

// File: tb/tb_ysyx_23060077_ex2wb.sv
// Bench for ysyx_23060077_ex2wb: directed vector table, hand-written corner sequences,
// then random traffic, all compared against a queue-based reference model.
module tb_ysyx_23060077_ex2wb;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_result;
    logic [31:0] in_imm;
    logic [31:0] in_src1;
    logic        in_branch;
    logic        in_jal;
    logic        in_jalr;
    logic [4:0]  in_rd;
    logic        in_rd_wen;
    logic        flush;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_wen;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_misalign;

    ysyx_23060077_ex2wb #(
        .DATA_WIDTH    (32),
        .REG_ADDR_WIDTH(5)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_pc            (in_pc),
        .in_result        (in_result),
        .in_imm           (in_imm),
        .in_src1          (in_src1),
        .in_branch        (in_branch),
        .in_jal           (in_jal),
        .in_jalr          (in_jalr),
        .in_rd            (in_rd),
        .in_rd_wen        (in_rd_wen),
        .flush            (flush),
        .wb_valid         (wb_valid),
        .wb_ready         (wb_ready),
        .wb_rd            (wb_rd),
        .wb_data          (wb_data),
        .wb_wen           (wb_wen),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .redirect_misalign(redirect_misalign)
    );

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] result;
        logic [31:0] imm;
        logic [31:0] src1;
        logic        branch;
        logic        jal;
        logic        jalr;
        logic [4:0]  rd;
        logic        rdWen;
        logic        flush;
        logic        wbReady;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic        expWbValid;
        logic [4:0]  expWbRd;
        logic [31:0] expWbData;
        logic        expWbWen;
        logic        expRedir;
        logic [31:0] expRedirPc;
        logic        expMis;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        wen;
    } entry_t;

    entry_t      modelQ[$];
    logic        mRv;
    logic [31:0] mRpc;
    logic        mRmis;
    int          vectors = 0;
    int          miscompares = 0;

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Hard stop in case anything stalls the run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s.valid = 1'b0; s.pc = '0; s.result = '0; s.imm = '0; s.src1 = '0;
        s.branch = 1'b0; s.jal = 1'b0; s.jalr = 1'b0; s.rd = '0; s.rdWen = 1'b0;
        s.flush = 1'b0; s.wbReady = 1'b1;
        return s;
    endfunction

    function automatic stim_t mk(input logic [31:0] pc, input logic [31:0] result,
                                 input logic [31:0] imm, input logic [31:0] src1,
                                 input logic br, input logic jal, input logic jalr,
                                 input logic [4:0] rd, input logic wen);
        stim_t s;
        s = idle();
        s.valid = 1'b1; s.pc = pc; s.result = result; s.imm = imm; s.src1 = src1;
        s.branch = br; s.jal = jal; s.jalr = jalr; s.rd = rd; s.rdWen = wen;
        return s;
    endfunction

    task automatic driveInputs(input stim_t s);
        in_valid  = s.valid;
        in_pc     = s.pc;
        in_result = s.result;
        in_imm    = s.imm;
        in_src1   = s.src1;
        in_branch = s.branch;
        in_jal    = s.jal;
        in_jalr   = s.jalr;
        in_rd     = s.rd;
        in_rd_wen = s.rdWen;
        flush     = s.flush;
        wb_ready  = s.wbReady;
    endtask

    // Drive one cycle of inputs, take the clock edge, and advance the reference model
    task automatic applyStimulus(input stim_t s);
        logic        acc;
        logic        outx;
        logic        take;
        logic [31:0] tgt;
        entry_t      e;
        driveInputs(s);
        acc  = s.valid && (modelQ.size() < 2) && !s.flush;
        outx = (modelQ.size() > 0) && s.wbReady;
        take = (s.branch && s.result[0]) || s.jal || s.jalr;
        if (s.jalr) tgt = (s.src1 + s.imm) & 32'hFFFF_FFFE;
        else tgt = s.pc + s.imm;
        e.rd   = s.rd;
        e.data = s.result;
        e.wen  = s.rdWen && (s.rd != 5'd0) && !s.branch;
        @(posedge clock);
        #1;
        if (s.flush) begin
            modelQ.delete();
        end else begin
            if (outx) void'(modelQ.pop_front());
            if (acc) modelQ.push_back(e);
        end
        mRv   = acc && take;
        mRpc  = mRv ? tgt : 32'h0;
        mRmis = mRv && tgt[1];
    endtask

    task automatic checkOutput();
        check("wb_valid", wb_valid, modelQ.size() > 0);
        check("in_ready", in_ready, modelQ.size() < 2);
        if (modelQ.size() > 0) begin
            check("wb_rd", wb_rd, modelQ[0].rd);
            check("wb_data", wb_data, modelQ[0].data);
            check("wb_wen", wb_wen, modelQ[0].wen);
        end
        check("redirect_valid", redirect_valid, mRv);
        check("redirect_pc", redirect_pc, mRpc);
        check("redirect_misalign", redirect_misalign, mRmis);
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, "_wb_valid"}, wb_valid, 1'b0);
        check({tag, "_wb_wen"}, wb_wen, 1'b0);
        check({tag, "_wb_rd"}, wb_rd, 5'd0);
        check({tag, "_wb_data"}, wb_data, 32'd0);
        check({tag, "_redirect_valid"}, redirect_valid, 1'b0);
        check({tag, "_redirect_pc"}, redirect_pc, 32'd0);
        check({tag, "_redirect_misalign"}, redirect_misalign, 1'b0);
    endtask

    initial begin
        vec_t        table_v[8];
        stim_t       s;
        logic [31:0] popped[$];
        bit          sent3;
        int          k;

        table_v[0].s = mk(32'h0, 32'h1234, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1);
        table_v[0].expWbValid = 1; table_v[0].expWbRd = 5; table_v[0].expWbData = 32'h1234;
        table_v[0].expWbWen = 1; table_v[0].expRedir = 0; table_v[0].expRedirPc = 0; table_v[0].expMis = 0;
        table_v[1].s = mk(32'h8000_0010, 32'h1, 32'hFFFF_FFF0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd3, 1'b1);
        table_v[1].expWbValid = 1; table_v[1].expWbRd = 3; table_v[1].expWbData = 32'h1;
        table_v[1].expWbWen = 0; table_v[1].expRedir = 1; table_v[1].expRedirPc = 32'h8000_0000; table_v[1].expMis = 0;
        table_v[2].s = mk(32'h8000_0020, 32'h8000_0024, 32'h4, 32'h8000_0103, 1'b0, 1'b0, 1'b1, 5'd1, 1'b1);
        table_v[2].expWbValid = 1; table_v[2].expWbRd = 1; table_v[2].expWbData = 32'h8000_0024;
        table_v[2].expWbWen = 1; table_v[2].expRedir = 1; table_v[2].expRedirPc = 32'h8000_0106; table_v[2].expMis = 1;
        table_v[3].s = mk(32'h0, 32'h55, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
        table_v[3].expWbValid = 1; table_v[3].expWbRd = 0; table_v[3].expWbData = 32'h55;
        table_v[3].expWbWen = 0; table_v[3].expRedir = 0; table_v[3].expRedirPc = 0; table_v[3].expMis = 0;
        table_v[4].s = mk(32'h200, 32'h2, 32'h40, 32'h0, 1'b1, 1'b0, 1'b0, 5'd7, 1'b0);
        table_v[4].expWbValid = 1; table_v[4].expWbRd = 7; table_v[4].expWbData = 32'h2;
        table_v[4].expWbWen = 0; table_v[4].expRedir = 0; table_v[4].expRedirPc = 0; table_v[4].expMis = 0;
        table_v[5].s = mk(32'h100, 32'h104, 32'h22, 32'hFFFF, 1'b0, 1'b1, 1'b0, 5'd1, 1'b1);
        table_v[5].expWbValid = 1; table_v[5].expWbRd = 1; table_v[5].expWbData = 32'h104;
        table_v[5].expWbWen = 1; table_v[5].expRedir = 1; table_v[5].expRedirPc = 32'h122; table_v[5].expMis = 1;
        table_v[6].s = mk(32'h1000, 32'h1004, 32'hFFFF_F000, 32'h0, 1'b0, 1'b1, 1'b0, 5'd31, 1'b1);
        table_v[6].expWbValid = 1; table_v[6].expWbRd = 31; table_v[6].expWbData = 32'h1004;
        table_v[6].expWbWen = 1; table_v[6].expRedir = 1; table_v[6].expRedirPc = 32'h0; table_v[6].expMis = 0;
        table_v[7].s = mk(32'h0, 32'h88, 32'hFFFF_FFFF, 32'h3, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0);
        table_v[7].expWbValid = 1; table_v[7].expWbRd = 9; table_v[7].expWbData = 32'h88;
        table_v[7].expWbWen = 0; table_v[7].expRedir = 1; table_v[7].expRedirPc = 32'h2; table_v[7].expMis = 1;

        // Reset state, then release so the first edge at t=15 can accept
        mRv = 0; mRpc = 0; mRmis = 0;
        reset_n = 1'b0;
        driveInputs(idle());
        #12;
        checkResetOutputs("reset");
        check("reset_in_ready", in_ready, 1'b1);
        reset_n = 1'b1;

        // Directed table: each vector is pushed, compared, then drained
        for (int i = 0; i < 8; i++) begin
            applyStimulus(table_v[i].s);
            checkOutput();
            check($sformatf("vec%0d_wb_valid", i), wb_valid, table_v[i].expWbValid);
            check($sformatf("vec%0d_wb_rd", i), wb_rd, table_v[i].expWbRd);
            check($sformatf("vec%0d_wb_data", i), wb_data, table_v[i].expWbData);
            check($sformatf("vec%0d_wb_wen", i), wb_wen, table_v[i].expWbWen);
            check($sformatf("vec%0d_redirect_valid", i), redirect_valid, table_v[i].expRedir);
            check($sformatf("vec%0d_redirect_pc", i), redirect_pc, table_v[i].expRedirPc);
            check($sformatf("vec%0d_redirect_mis", i), redirect_misalign, table_v[i].expMis);
            applyStimulus(idle());
            checkOutput();
            check($sformatf("vec%0d_pulse_end", i), redirect_valid, 1'b0);
        end

        // Back-pressure: three pushes with the consumer stalled, then in-order drain
        for (int i = 1; i <= 2; i++) begin
            s = mk(32'h0, i, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'(i), 1'b1);
            s.wbReady = 1'b0;
            applyStimulus(s);
            checkOutput();
        end
        check("bp_in_ready_full", in_ready, 1'b0);
        s = mk(32'h0, 32'd3, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd3, 1'b1);
        s.wbReady = 1'b0;
        applyStimulus(s);
        checkOutput();
        check("bp_third_held", wb_data, 32'd1);
        sent3 = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (sent3 && !wb_valid) break;
            s = idle();
            if (!sent3) s = mk(32'h0, 32'd3, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd3, 1'b1);
            if (wb_valid) popped.push_back(wb_data);
            if (s.valid && in_ready) sent3 = 1'b1;
            applyStimulus(s);
            checkOutput();
        end
        check("bp_drain_count", popped.size(), 3);
        for (int i = 0; i < popped.size() && i < 3; i++)
            check($sformatf("bp_order%0d", i), popped[i], i + 1);

        // Flush while full with a simultaneous taken JAL
        for (int i = 0; i < 2; i++) begin
            s = mk(32'h0, 32'hA0 + i, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd4, 1'b1);
            s.wbReady = 1'b0;
            applyStimulus(s);
            checkOutput();
        end
        s = mk(32'h400, 32'h404, 32'h10, 32'h0, 1'b0, 1'b1, 1'b0, 5'd1, 1'b1);
        s.flush = 1'b1;
        s.wbReady = 1'b0;
        applyStimulus(s);
        checkOutput();
        check("flush_full_wb_valid", wb_valid, 1'b0);
        check("flush_full_in_ready", in_ready, 1'b1);
        check("flush_full_redirect", redirect_valid, 1'b0);

        // Flush while holding one entry, where the JAL would otherwise be accepted
        s = mk(32'h0, 32'hB0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd6, 1'b1);
        s.wbReady = 1'b0;
        applyStimulus(s);
        checkOutput();
        s = mk(32'h400, 32'h404, 32'h10, 32'h0, 1'b0, 1'b1, 1'b0, 5'd1, 1'b1);
        s.flush = 1'b1;
        applyStimulus(s);
        checkOutput();
        check("flush_one_redirect", redirect_valid, 1'b0);
        check("flush_one_wb_valid", wb_valid, 1'b0);

        // Asynchronous reset mid-operation with a full FIFO and a live redirect
        s = mk(32'h0, 32'hC0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd8, 1'b1);
        s.wbReady = 1'b0;
        applyStimulus(s);
        s = mk(32'h800, 32'h804, 32'h8, 32'h0, 1'b0, 1'b1, 1'b0, 5'd1, 1'b1);
        s.wbReady = 1'b0;
        applyStimulus(s);
        checkOutput();
        driveInputs(idle());
        #2;
        reset_n = 1'b0;
        #1;
        checkResetOutputs("midreset");
        modelQ.delete();
        mRv = 0; mRpc = 0; mRmis = 0;
        reset_n = 1'b1;
        applyStimulus(mk(32'h0, 32'hD0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd2, 1'b1));
        checkOutput();
        check("first_edge_accept", wb_valid, 1'b1);

        // Random traffic against the reference model
        for (int c = 0; c < 600; c++) begin
            s = idle();
            s.valid   = ($urandom_range(0, 9) < 7);
            s.pc      = $urandom & 32'hFFFF_FFFC;
            s.result  = $urandom;
            s.imm     = $urandom;
            s.src1    = $urandom;
            k = $urandom_range(0, 3);
            s.branch  = (k == 1);
            s.jal     = (k == 2);
            s.jalr    = (k == 3);
            s.rd      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            s.rdWen   = $urandom_range(0, 1);
            s.flush   = ($urandom_range(0, 15) == 0);
            s.wbReady = ($urandom_range(0, 9) < 6);
            applyStimulus(s);
            checkOutput();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
